// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port 256-byte memory between instruction fetch and data access
module unified_mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk_90,
    input  logic        rst_90,
    input  logic        if_req,
    input  logic [7:0]  if_addr,
    output logic        if_gnt,
    output logic        if_stall,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [7:0]  dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam logic [2:0] SMAX  = 3'(STARVE_MAX);
    localparam logic [1:0] NONE  = 2'd0;
    localparam logic [1:0] IF_RD = 2'd1;
    localparam logic [1:0] DM_RD = 2'd2;

    logic [1:0]  owner;
    logic [1:0]  owner_nxt;
    logic [2:0]  starve_cnt;
    logic [31:0] if_hold;
    logic [31:0] dm_hold;

    // grant selection: data wins unless fetch has been starved long enough
    always_comb begin
        if_gnt    = if_req & (!dm_req | (starve_cnt == SMAX));
        dm_gnt    = dm_req & !if_gnt;
        if_stall  = if_req & !if_gnt;
        mem_en    = if_gnt | (dm_gnt & !dm_we);
        mem_we    = dm_gnt & dm_we;
        mem_addr  = if_gnt ? if_addr : dm_gnt ? dm_addr : 8'd0;
        mem_wdata = mem_we ? dm_wdata : 32'd0;
        owner_nxt = if_gnt ? IF_RD : (dm_gnt & !dm_we) ? DM_RD : NONE;
    end

    // steer the registered memory read data to whoever issued last cycle's read
    always_comb begin
        if_rvalid = owner == IF_RD;
        dm_rvalid = owner == DM_RD;
        if_rdata  = if_rvalid ? mem_rdata : if_hold;
        dm_rdata  = dm_rvalid ? mem_rdata : dm_hold;
    end

    // owner tracking, starvation counting and last-delivered data hold
    always_ff @(posedge clk_90 or negedge rst_90) begin
        if (!rst_90) begin
            owner      <= NONE;
            starve_cnt <= 3'd0;
            if_hold    <= 32'd0;
            dm_hold    <= 32'd0;
        end else begin
            owner      <= owner_nxt;
            starve_cnt <= if_stall ? ((starve_cnt == SMAX) ? starve_cnt : starve_cnt + 3'd1) : 3'd0;
            if (if_rvalid) if_hold <= mem_rdata;
            if (dm_rvalid) dm_hold <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed and random checks of the arbiter against a cycle-level reference model
module tb_unified_mem_arbiter;
    localparam int SMAX = 4;

    logic        clk_90 = 1'b0;
    logic        rst_90 = 1'b0;
    logic        if_req = 1'b0;
    logic [7:0]  if_addr = 8'd0;
    logic        if_gnt, if_stall, if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [7:0]  dm_addr = 8'd0;
    logic [31:0] dm_wdata = 32'd0;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];

    int          denied = 0;
    int          pend = 0;
    logic [31:0] pdata = 32'd0;
    logic [31:0] if_last = 32'd0;
    logic [31:0] dm_last = 32'd0;

    unified_mem_arbiter #(.STARVE_MAX(SMAX)) dut (
        .clk_90(clk_90), .rst_90(rst_90),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_stall(if_stall),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk_90 = ~clk_90;

    // memory model: registered read, little-endian byte storage
    always @(posedge clk_90) begin
        if (mem_en) mem_rdata <= {mem[mem_addr + 8'd3], mem[mem_addr + 8'd2], mem[mem_addr + 8'd1], mem[mem_addr]};
        if (mem_we) {mem[mem_addr + 8'd3], mem[mem_addr + 8'd2], mem[mem_addr + 8'd1], mem[mem_addr]} <= mem_wdata;
    end

    function automatic logic [31:0] ref_rd(input logic [7:0] a);
        return {ref_mem[a + 8'd3], ref_mem[a + 8'd2], ref_mem[a + 8'd1], ref_mem[a]};
    endfunction

    task automatic preload(input logic [7:0] a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            mem[a + 8'(k)] = w[8*k +: 8];
            ref_mem[a + 8'(k)] = w[8*k +: 8];
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        denied = 0;
        pend = 0;
        if_last = 32'd0;
        dm_last = 32'd0;
    endtask

    // one clock cycle: drive, check against the model, advance the model
    task automatic step(input logic ir, input logic [7:0] ia, input logic dr, input logic dw,
                        input logic [7:0] da, input logic [31:0] dwd);
        logic eig, edg;
        @(negedge clk_90);
        if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dwd;
        #1;
        eig = ir && (!dr || denied >= SMAX);
        edg = dr && !eig;
        chk("if_gnt", 32'(if_gnt), 32'(eig));
        chk("dm_gnt", 32'(dm_gnt), 32'(edg));
        chk("if_stall", 32'(if_stall), 32'(ir && !eig));
        chk("mem_en", 32'(mem_en), 32'(eig || (edg && !dw)));
        chk("mem_we", 32'(mem_we), 32'(edg && dw));
        chk("mem_addr", 32'(mem_addr), 32'(eig ? ia : edg ? da : 8'd0));
        if (edg && dw) chk("mem_wdata", mem_wdata, dwd);
        if (!eig && !edg) chk("mem_wdata_idle", mem_wdata, 32'd0);
        chk("if_rvalid", 32'(if_rvalid), 32'(pend == 1));
        chk("dm_rvalid", 32'(dm_rvalid), 32'(pend == 2));
        if (pend == 1) if_last = pdata;
        if (pend == 2) dm_last = pdata;
        chk("if_rdata", if_rdata, if_last);
        chk("dm_rdata", dm_rdata, dm_last);
        denied = (ir && !eig) ? ((denied < SMAX) ? denied + 1 : SMAX) : 0;
        pend = 0;
        if (eig) begin
            pend = 1;
            pdata = ref_rd(ia);
        end else if (edg && !dw) begin
            pend = 2;
            pdata = ref_rd(da);
        end else if (edg && dw) begin
            for (int k = 0; k < 4; k++) ref_mem[da + 8'(k)] = dwd[8*k +: 8];
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'({if_gnt, dm_gnt, if_stall}), 32'd0);
        chk({tag, "_mem"}, 32'({mem_en, mem_we}) | 32'(mem_addr) | mem_wdata, 32'd0);
        chk({tag, "_rvalid"}, 32'({if_rvalid, dm_rvalid}), 32'd0);
        chk({tag, "_if_rdata"}, if_rdata, 32'd0);
        chk({tag, "_dm_rdata"}, dm_rdata, 32'd0);
    endtask

    initial begin
        logic        ir, dr, dw;
        logic [7:0]  ia, da;
        logic [31:0] wd;
        for (int k = 0; k < 256; k++) begin
            mem[k] = 8'($urandom);
            ref_mem[k] = mem[k];
        end
        preload(8'd0, 32'h00000821);
        preload(8'd4, 32'h10E00008);
        preload(8'd8, 32'h8C620000);

        // reset with no requests, then 10 idle cycles
        #2;
        chk_all_zero("in_reset");
        repeat (2) @(negedge clk_90);
        rst_90 = 1'b1;
        model_reset();
        idle(10);

        // fetch only
        step(1'b1, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0);
        step(1'b1, 8'd4, 1'b0, 1'b0, 8'd0, 32'd0);
        chk("fetch_w0", if_rdata, 32'h00000821);
        step(1'b1, 8'd8, 1'b0, 1'b0, 8'd0, 32'd0);
        chk("fetch_w1", if_rdata, 32'h10E00008);
        idle(1);
        chk("fetch_w2", if_rdata, 32'h8C620000);

        // simultaneous requests with word 1 at address 8
        step(1'b0, 8'd0, 1'b1, 1'b1, 8'd8, 32'd1);
        step(1'b1, 8'd12, 1'b1, 1'b0, 8'd8, 32'd0);
        chk("simul_stall", 32'(if_stall), 32'd1);
        idle(1);
        chk("simul_dm_rdata", dm_rdata, 32'd1);
        chk("simul_if_rvalid", 32'(if_rvalid), 32'd0);

        // starvation: DM,DM,DM,DM,IF repeating
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'd16, 1'b1, 1'b0, 8'($urandom_range(0, 63) * 4), 32'd0);
            chk("starve_pattern", 32'(if_gnt), 32'(i % 5 == 4));
        end
        idle(1);

        // write then read back
        step(1'b0, 8'd0, 1'b1, 1'b1, 8'd40, 32'hDEADBEEF);
        chk("wr_dm_rvalid", 32'(dm_rvalid), 32'd0);
        step(1'b0, 8'd0, 1'b1, 1'b0, 8'd40, 32'd0);
        chk("wr_pulse_gone", 32'(mem_we), 32'd0);
        idle(1);
        chk("wr_readback", dm_rdata, 32'hDEADBEEF);

        // reset while a fetch read is outstanding
        step(1'b1, 8'd4, 1'b0, 1'b0, 8'd0, 32'd0);
        @(negedge clk_90);
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; if_addr = 8'd0; dm_addr = 8'd0; dm_wdata = 32'd0;
        rst_90 = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        @(negedge clk_90);
        rst_90 = 1'b1;
        model_reset();
        idle(3);

        // random traffic; unserved requests are held stable until granted
        ir = 0; dr = 0; dw = 0; ia = 0; da = 0; wd = 0;
        for (int i = 0; i < 400; i++) begin
            if (!ir || if_gnt) begin
                ir = ($urandom_range(0, 3) != 0);
                ia = 8'($urandom_range(0, 63) * 4);
            end
            if (!dr || dm_gnt) begin
                dr = ($urandom_range(0, 2) != 0);
                dw = ($urandom_range(0, 2) == 0);
                da = 8'($urandom_range(0, 63) * 4);
                wd = $urandom;
            end
            step(ir, ia, dr, dw, da, wd);
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
